// File: rtl/hazard_pkg.sv
// Shared types and kill-mask constants for the hazard field and its per-player FSMs.
package hazard_pkg;

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        DYING = 2'd1,
        DEAD  = 2'd2
    } player_state_e;

    localparam logic [1:0] KILL_P1  = 2'b01;
    localparam logic [1:0] KILL_P2  = 2'b10;
    localparam logic [1:0] KILL_ALL = 2'b11;

    typedef struct packed {
        shortint top;
        shortint bottom;
        shortint left;
        shortint right;
    } box_t;

endpackage

// File: rtl/hazard_field_if.sv
// Frame/player-box inputs and hazard/player status outputs of the hazard field.
interface hazard_field_if #(
    parameter int HAZ_COUNT = 3,
    parameter int PLAYERS   = 2
);
    localparam int KW = (HAZ_COUNT > 1) ? $clog2(HAZ_COUNT) : 1;

    logic                 frame_tick;
    logic                 level_clear;
    shortint              player_top    [PLAYERS];
    shortint              player_bottom [PLAYERS];
    shortint              player_left   [PLAYERS];
    shortint              player_right  [PLAYERS];
    logic [HAZ_COUNT-1:0] hazard_active;
    logic [PLAYERS-1:0]   player_dying;
    logic [PLAYERS-1:0]   player_dead;
    logic                 any_dead;
    logic [KW-1:0]        killer_id     [PLAYERS];

    modport master (
        output frame_tick, level_clear, player_top, player_bottom, player_left, player_right,
        input  hazard_active, player_dying, player_dead, any_dead, killer_id
    );

    modport slave (
        input  frame_tick, level_clear, player_top, player_bottom, player_left, player_right,
        output hazard_active, player_dying, player_dead, any_dead, killer_id
    );
endinterface

// File: rtl/hazard_player_fsm.sv
// One player's ALIVE -> DYING -> DEAD tracker with dwell filter and death timer.
// HAZARD_KILLER_ID_EN builds the register that remembers which hazard made the kill.
module hazard_player_fsm
    import hazard_pkg::*;
#(
    parameter int HAZ_COUNT    = 3,
    parameter int DWELL_FRAMES = 2,
    parameter int DEATH_FRAMES = 30,
    parameter int KW           = (HAZ_COUNT > 1) ? $clog2(HAZ_COUNT) : 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_tick,
    input  logic                 level_clear,
    input  logic [HAZ_COUNT-1:0] lethal,
    output logic                 dying,
    output logic                 dead,
    output logic [KW-1:0]        killer_id
);
    localparam int DW_W = $clog2(DWELL_FRAMES + 1);
    localparam int DT_W = $clog2(DEATH_FRAMES + 1);

    player_state_e   state_q, state_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    logic [DT_W-1:0] death_q, death_d;
    logic            hit;

    assign hit = |lethal;

    always_ff @(posedge Clk) begin
        if (Reset || level_clear) begin
            state_q <= ALIVE;
            dwell_q <= '0;
            death_q <= '0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            death_q <= death_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        death_d = death_q;
        if (frame_tick) begin
            unique case (state_q)
                ALIVE: begin
                    if (!hit) begin
                        dwell_d = '0;
                    end else if (int'(dwell_q) + 1 >= DWELL_FRAMES) begin
                        state_d = DYING;
                        dwell_d = '0;
                        death_d = '0;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                // Death counter reaching DEATH_FRAMES-1 means that many ticks already elapsed.
                DYING: begin
                    if (int'(death_q) == DEATH_FRAMES - 1) state_d = DEAD;
                    else                                   death_d = death_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dying = (state_q == DYING);
    assign dead  = (state_q == DEAD);

`ifdef HAZARD_KILLER_ID_EN
    logic          take_kill;
    logic [KW-1:0] first_lethal;
    logic [KW-1:0] killer_q;

    assign take_kill = frame_tick && (state_q == ALIVE) && (state_d == DYING);

    always_comb begin
        first_lethal = '0;
        for (int h = HAZ_COUNT - 1; h >= 0; h--) begin
            if (lethal[h]) first_lethal = KW'(h);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset || level_clear) killer_q <= '0;
        else if (take_kill)       killer_q <= first_lethal;
    end

    assign killer_id = killer_q;
`else
    assign killer_id = '0;
`endif

endmodule

// File: rtl/hazard_field.sv
// Rectangular hazards vs player boxes: phase counter, overlap matrix and per-player kill FSMs.
// Optional macro HAZARD_KILLER_ID_EN enables the killer_id outputs.
module hazard_field
    import hazard_pkg::*;
#(
    parameter int                   HAZ_COUNT = 3,
    parameter int                   PLAYERS   = 2,
    parameter shortint              HAZ_X     [HAZ_COUNT] = '{300, 428, 396},
    parameter shortint              HAZ_Y     [HAZ_COUNT] = '{463, 463, 365},
    parameter int                   HAZ_W     = 76,
    parameter int                   HAZ_H     = 5,
    parameter logic [PLAYERS-1:0]   KILL_MASK [HAZ_COUNT] = '{KILL_P2, KILL_P1, KILL_ALL},
    parameter logic [HAZ_COUNT-1:0] PERIODIC  = 3'b100,
    parameter int                   ON_FRAMES    = 60,
    parameter int                   OFF_FRAMES   = 60,
    parameter int                   DWELL_FRAMES = 2,
    parameter int                   DEATH_FRAMES = 30
) (
    input logic           Clk,
    input logic           Reset,
    hazard_field_if.slave bus
);
    localparam int PERIOD = ON_FRAMES + OFF_FRAMES;
    localparam int PH_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int KW     = (HAZ_COUNT > 1) ? $clog2(HAZ_COUNT) : 1;

    logic [PH_W-1:0]      phase_q, phase_d;
    logic [HAZ_COUNT-1:0] active_q, active_d;
    box_t                 box    [PLAYERS];
    logic [HAZ_COUNT-1:0] lethal [PLAYERS];
    logic [PLAYERS-1:0]   dying, dead;
    logic [KW-1:0]        killer [PLAYERS];

    function automatic logic overlaps(box_t b, int h);
        shortint x_end, y_end;
        x_end = shortint'(int'(HAZ_X[h]) + HAZ_W);
        y_end = shortint'(int'(HAZ_Y[h]) + HAZ_H);
        return (b.right > HAZ_X[h]) && (b.left < x_end) &&
               (b.bottom > HAZ_Y[h]) && (b.top < y_end);
    endfunction

    // Active flags are derived from the post-tick phase so they move with the phase register.
    always_comb begin
        phase_d = phase_q;
        if (bus.level_clear)
            phase_d = '0;
        else if (bus.frame_tick)
            phase_d = (phase_q == PH_W'(PERIOD - 1)) ? '0 : phase_q + 1'b1;
        for (int h = 0; h < HAZ_COUNT; h++)
            active_d[h] = !PERIODIC[h] || (int'(phase_d) < ON_FRAMES);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            phase_q  <= '0;
            active_q <= '1;
        end else begin
            phase_q  <= phase_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        for (int p = 0; p < PLAYERS; p++)
            for (int h = 0; h < HAZ_COUNT; h++)
                lethal[p][h] = overlaps(box[p], h) && KILL_MASK[h][p] && active_q[h];
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        assign box[p] = '{top:    bus.player_top[p],
                          bottom: bus.player_bottom[p],
                          left:   bus.player_left[p],
                          right:  bus.player_right[p]};

        hazard_player_fsm #(
            .HAZ_COUNT    (HAZ_COUNT),
            .DWELL_FRAMES (DWELL_FRAMES),
            .DEATH_FRAMES (DEATH_FRAMES),
            .KW           (KW)
        ) u_fsm (
            .Clk         (Clk),
            .Reset       (Reset),
            .frame_tick  (bus.frame_tick),
            .level_clear (bus.level_clear),
            .lethal      (lethal[p]),
            .dying       (dying[p]),
            .dead        (dead[p]),
            .killer_id   (killer[p])
        );

        assign bus.killer_id[p] = killer[p];
    end

    assign bus.hazard_active = active_q;
    assign bus.player_dying  = dying;
    assign bus.player_dead   = dead;
    assign bus.any_dead      = |dead;

endmodule

// File: tb/tb_hazard_field.sv
// Bench for hazard_field: directed scenarios plus randomized traffic against a frame-level model.
`timescale 1ns/1ps
module tb_hazard_field;
    import hazard_pkg::*;

    localparam int HC = 3;
    localparam int NP = 2;
    localparam int HX [HC] = '{300, 428, 396};
    localparam int HY [HC] = '{463, 463, 365};
    localparam int HW = 76;
    localparam int HH = 5;
    localparam logic [1:0] KM [HC] = '{2'b10, 2'b01, 2'b11};
    localparam logic [2:0] PER = 3'b100;
    localparam int ON = 60;
    localparam int OFF = 60;
    localparam int DWELL = 2;
    localparam int DEATH = 30;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    hazard_field_if #(.HAZ_COUNT(HC), .PLAYERS(NP)) bus ();
    hazard_field dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: frames since clear, hit streak, ticks spent dying.
    int m_frames;
    int m_stage  [NP];
    int m_streak [NP];
    int m_dyt    [NP];
    int m_killer [NP];

    function automatic bit m_on(int h);
        return !PER[h] || ((m_frames % (ON + OFF)) < ON);
    endfunction

    function automatic bit geom(int h, int p);
        shortint t, b, l, r;
        t = bus.player_top[p];
        b = bus.player_bottom[p];
        l = bus.player_left[p];
        r = bus.player_right[p];
        return (r > shortint'(HX[h])) && (l < shortint'(HX[h] + HW)) &&
               (b > shortint'(HY[h])) && (t < shortint'(HY[h] + HH));
    endfunction

    task automatic model_clear();
        m_frames = 0;
        for (int p = 0; p < NP; p++) begin
            m_stage[p] = 0; m_streak[p] = 0; m_dyt[p] = 0; m_killer[p] = 0;
        end
    endtask

    always @(posedge Clk) begin
        if (Reset || bus.level_clear) begin
            model_clear();
        end else if (bus.frame_tick) begin
            for (int p = 0; p < NP; p++) begin
                int first;
                first = -1;
                for (int h = HC - 1; h >= 0; h--)
                    if (m_on(h) && KM[h][p] && geom(h, p)) first = h;
                if (m_stage[p] == 0) begin
                    if (first >= 0) begin
                        m_streak[p]++;
                        if (m_streak[p] >= DWELL) begin
                            m_stage[p] = 1; m_dyt[p] = 0; m_killer[p] = first;
                        end
                    end else begin
                        m_streak[p] = 0;
                    end
                end else if (m_stage[p] == 1) begin
                    m_dyt[p]++;
                    if (m_dyt[p] == DEATH) m_stage[p] = 2;
                end
            end
            m_frames++;
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            int e_act, e_dy, e_dd;
            e_act = 0; e_dy = 0; e_dd = 0;
            for (int h = 0; h < HC; h++) if (m_on(h)) e_act |= (1 << h);
            for (int p = 0; p < NP; p++) begin
                if (m_stage[p] == 1) e_dy |= (1 << p);
                if (m_stage[p] == 2) e_dd |= (1 << p);
            end
            check("hazard_active", int'(bus.hazard_active), e_act);
            check("player_dying", int'(bus.player_dying), e_dy);
            check("player_dead", int'(bus.player_dead), e_dd);
            check("any_dead", int'(bus.any_dead), int'(e_dd != 0));
            for (int p = 0; p < NP; p++) begin
`ifdef HAZARD_KILLER_ID_EN
                check("killer_id", int'(bus.killer_id[p]), m_killer[p]);
`else
                check("killer_id", int'(bus.killer_id[p]), 0);
`endif
            end
        end
    end

    task automatic set_box(int p, int t, int b, int l, int r);
        bus.player_top[p]    = shortint'(t);
        bus.player_bottom[p] = shortint'(b);
        bus.player_left[p]   = shortint'(l);
        bus.player_right[p]  = shortint'(r);
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        @(posedge Clk); #2;
        bus.frame_tick = 1'b0;
        @(posedge Clk); #2;
    endtask

    task automatic clear();
        bus.level_clear = 1'b1;
        @(posedge Clk); #2;
        bus.level_clear = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        bus.frame_tick = 1'b0;
        bus.level_clear = 1'b0;
        set_box(0, 0, 10, 0, 10);
        set_box(1, 0, 10, 0, 10);
        repeat (2) @(posedge Clk);
        #2;
        Reset = 1'b0;
        chk_en = 1'b1;
        check("lit_reset_active", int'(bus.hazard_active), 7);
        check("lit_reset_dying", int'(bus.player_dying), 0);
        check("lit_reset_dead", int'(bus.player_dead), 0);

        // Both players on hazard 0; only player2 is killable by it.
        set_box(0, 455, 470, 320, 340);
        set_box(1, 455, 470, 320, 340);
        tick();
        check("lit_p2_dwell1", int'(bus.player_dying), 0);
        tick();
        check("lit_p2_dying", int'(bus.player_dying), 2);
        repeat (29) tick();
        check("lit_p2_not_yet_dead", int'(bus.player_dead), 0);
        tick();
        check("lit_p2_dead", int'(bus.player_dead), 2);
        check("lit_any_dead", int'(bus.any_dead), 1);
        check("lit_p2_killer", int'(bus.killer_id[1]), 0);
        check("lit_p1_survives", int'(bus.player_dying) | int'(bus.player_dead), 2);

        // Broken dwell on hazard 1.
        clear();
        set_box(1, 0, 10, 0, 10);
        set_box(0, 455, 470, 440, 460);
        tick();
        set_box(0, 0, 10, 0, 10);
        tick();
        set_box(0, 455, 470, 440, 460);
        tick();
        check("lit_broken_dwell", int'(bus.player_dying), 0);
        tick();
        check("lit_dwell_kill", int'(bus.player_dying), 1);
`ifdef HAZARD_KILLER_ID_EN
        check("lit_killer_h1", int'(bus.killer_id[0]), 1);
`endif

        // Periodic hazard 2.
        clear();
        set_box(0, 0, 10, 0, 10);
        repeat (60) tick();
        check("lit_h2_off", int'(bus.hazard_active), 3);
        set_box(0, 360, 368, 400, 420);
        repeat (60) tick();
        check("lit_h2_off_no_death", int'(bus.player_dying), 0);
        check("lit_h2_back_on", int'(bus.hazard_active), 7);
        tick();
        check("lit_h2_dwell1", int'(bus.player_dying), 0);
        tick();
        check("lit_h2_dying", int'(bus.player_dying), 1);
`ifdef HAZARD_KILLER_ID_EN
        check("lit_killer_h2", int'(bus.killer_id[0]), 2);
`endif

        // level_clear beats a simultaneous frame_tick.
        bus.level_clear = 1'b1;
        bus.frame_tick = 1'b1;
        @(posedge Clk); #2;
        bus.level_clear = 1'b0;
        bus.frame_tick = 1'b0;
        check("lit_clr_dying", int'(bus.player_dying), 0);
        check("lit_clr_dead", int'(bus.player_dead), 0);
        check("lit_clr_active", int'(bus.hazard_active), 7);
        check("lit_clr_killer", int'(bus.killer_id[0]), 0);

        // Randomized traffic around the hazards.
        for (int i = 0; i < 5000; i++) begin
            bus.frame_tick  = 1'($urandom_range(0, 1));
            bus.level_clear = ($urandom_range(0, 299) == 0);
            Reset           = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 5) == 0) begin
                int p, h, l, t;
                p = $urandom_range(0, NP - 1);
                h = $urandom_range(0, HC - 1);
                if ($urandom_range(0, 4) == 0) begin
                    set_box(p, 0, 10, 0, 10);
                end else begin
                    l = HX[h] - 40 + $urandom_range(0, 120);
                    t = HY[h] - 20 + $urandom_range(0, 30);
                    set_box(p, t, t + $urandom_range(0, 20), l, l + $urandom_range(0, 40));
                end
            end
            @(posedge Clk); #2;
        end
        Reset = 1'b0;
        bus.frame_tick = 1'b0;
        bus.level_clear = 1'b0;
        @(posedge Clk); #2;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
